// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter / sequencer sharing one WIDTH-bit datapath between
//   four valid/ready requesters. The winning requester's word is registered
//   onto a single valid/ready output port. A burst (beats until in_last)
//   keeps the grant until its last beat has been transferred.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   4      per-requester valid, bit i = requester i
//   in_data0-3 in   WIDTH  per-requester data
//   in_last    in   4      per-requester last-beat-of-burst flag
//   in_ready   out  4      per-requester ready (combinational, one-hot or 0)
//   out_valid  out  1      registered output valid
//   out_data   out  WIDTH  registered selected data
//   out_last   out  1      registered last flag of the beat on out_data
//   out_sel    out  2      requester that supplied out_data
//   out_ready  in   1      downstream ready
//   locked     out  1      high while a burst is in progress
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    input  logic [3:0]       in_last,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       out_sel,
    input  logic             out_ready,
    output logic             locked
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_n_s;
    logic [1:0]       prio_ptr_r;
    logic [1:0]       prio_ptr_n_s;
    logic [1:0]       grant_q_r;
    logic [1:0]       grant_q_n_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic [1:0]       out_sel_r;

    logic [1:0]       arb_idx_s;
    logic [1:0]       idx_v_s;
    logic [1:0]       cur_s;
    logic             locked_s;
    logic             can_load_s;
    logic             xfer_s;
    logic [WIDTH-1:0] sel_data_s;
    logic             sel_last_s;
    logic [3:0]       in_ready_s;

    assign locked_s   = (state_r == LOCKED);
    assign can_load_s = ~out_valid_r | out_ready;

    // Cyclic search from prio_ptr; walking offsets high-to-low lets the
    // lowest offset with a valid request overwrite the others.
    always_comb begin
        arb_idx_s = 2'd0;
        idx_v_s   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx_v_s   = prio_ptr_r + 2'(k);
            arb_idx_s = in_valid[idx_v_s] ? idx_v_s : arb_idx_s;
        end
    end

    assign cur_s = locked_s ? grant_q_r : arb_idx_s;

    // Ready to the current requester only; during a burst the owner sees
    // ready even without valid so bubbles never release the grant.
    always_comb begin
        in_ready_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_ready_s[i] = rst_n & can_load_s & (cur_s == 2'(i)) &
                            (locked_s | in_valid[i]);
        end
    end

    assign in_ready = in_ready_s;
    assign xfer_s   = in_valid[cur_s] & in_ready_s[cur_s];

    // Data/last mux for the current requester; other inputs never propagate.
    always_comb begin
        sel_data_s = '0;
        sel_last_s = 1'b0;
        case (cur_s)
            2'd0: begin sel_data_s = in_data0; sel_last_s = in_last[0]; end
            2'd1: begin sel_data_s = in_data1; sel_last_s = in_last[1]; end
            2'd2: begin sel_data_s = in_data2; sel_last_s = in_last[2]; end
            2'd3: begin sel_data_s = in_data3; sel_last_s = in_last[3]; end
            default: begin sel_data_s = '0; sel_last_s = 1'b0; end
        endcase
    end

    // Next-state logic for burst locking and round-robin pointer rotation.
    always_comb begin
        state_n_s    = state_r;
        prio_ptr_n_s = prio_ptr_r;
        grant_q_n_s  = grant_q_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && sel_last_s) begin
                    prio_ptr_n_s = cur_s + 2'd1;
                end else if (xfer_s) begin
                    state_n_s   = LOCKED;
                    grant_q_n_s = cur_s;
                end else begin
                    state_n_s = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    state_n_s    = IDLE;
                    prio_ptr_n_s = grant_q_r + 2'd1;
                end else begin
                    state_n_s = LOCKED;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            prio_ptr_r <= 2'd0;
            grant_q_r  <= 2'd0;
        end else begin
            state_r    <= state_n_s;
            prio_ptr_r <= prio_ptr_n_s;
            grant_q_r  <= grant_q_n_s;
        end
    end

    // Single output register: load on transfer, drain when accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_sel_r   <= 2'd0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_last_r  <= sel_last_s;
            out_sel_r   <= cur_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_sel   = out_sel_r;
    assign locked    = locked_s;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [7:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_sel;
    logic       out_ready;
    logic       locked;

    int total = 0;
    int bad   = 0;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1),
        .in_data2(in_data2), .in_data3(in_data3),
        .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic [3:0] last;
        logic       ordy;
        logic [7:0] d0, d1, d2, d3;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_sel;
        logic       e_ol;
        logic       e_lk;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [3:0] val, logic [3:0] last, logic ordy,
                                logic [7:0] d0, logic [7:0] d1, logic [7:0] d2, logic [7:0] d3,
                                logic [3:0] e_rdy, logic e_ov, logic [7:0] e_od,
                                logic [1:0] e_sel, logic e_ol, logic e_lk);
        vec_t v;
        v.rst = rst; v.val = val; v.last = last; v.ordy = ordy;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od;
        v.e_sel = e_sel; v.e_ol = e_ol; v.e_lk = e_lk;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_owner;   // -1 when no burst is open
    int         m_ptr;
    logic       m_ov;
    logic [7:0] m_od;
    logic       m_ol;
    int         m_os;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_ov = 1'b0; m_od = 8'h00; m_ol = 1'b0; m_os = 0;
    endtask

    function automatic int model_pick();
        if (m_owner >= 0) return m_owner;
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        logic [3:0] r;
        int p;
        r = 4'b0000;
        p = model_pick();
        if (p >= 0 && (!m_ov || out_ready) && (m_owner >= 0 || in_valid[p])) r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] data_of(int i);
        case (i)
            0: return in_data0;
            1: return in_data1;
            2: return in_data2;
            default: return in_data3;
        endcase
    endfunction

    task automatic model_step();
        int p;
        p = model_pick();
        if (p >= 0 && (!m_ov || out_ready) && in_valid[p]) begin
            m_ov = 1'b1; m_od = data_of(p); m_ol = in_last[p]; m_os = p;
            if (in_last[p]) begin
                m_owner = -1;
                m_ptr = (p + 1) % 4;
            end else begin
                m_owner = p;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    vec_t tbl[24];

    initial begin
        int wait_cnt[4];
        int prev_j;
        logic prev_open;
        logic [3:0] hs;
        int j;

        rst_n = 1'b0;
        in_valid = 4'b0000; in_last = 4'b0000; out_ready = 1'b1;
        in_data0 = 8'h00; in_data1 = 8'h00; in_data2 = 8'h00; in_data3 = 8'h00;

        // rst val  last  ordy d0 d1 d2 d3 | rdy ov od sel ol lk
        tbl[0]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 4'hF, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 4'h0, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1, 1'b0);
        // single beat from reset
        tbl[6]  = mk(1'b1, 4'h1, 4'hF, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0);
        // burst on req1 while req2 waits
        tbl[7]  = mk(1'b0, 4'h6, 4'h0, 1'b1, 8'h11, 8'hAA, 8'h55, 8'h44, 4'b0010, 1'b1, 8'hAA, 2'd1, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 4'h6, 4'h0, 1'b1, 8'h11, 8'hBB, 8'h55, 8'h44, 4'b0010, 1'b1, 8'hBB, 2'd1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 4'h6, 4'h2, 1'b1, 8'h11, 8'hCC, 8'h55, 8'h44, 4'b0010, 1'b1, 8'hCC, 2'd1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 4'h4, 4'h4, 1'b1, 8'h11, 8'hCC, 8'h55, 8'h44, 4'b0100, 1'b1, 8'h55, 2'd2, 1'b1, 1'b0);
        // pointer wrap 3 -> 0
        tbl[11] = mk(1'b0, 4'h9, 4'h9, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 4'h9, 4'h9, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0);
        // backpressure: 33 held four cycles, pending 77 follows exactly once
        tbl[13] = mk(1'b0, 4'h4, 4'h4, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 4'h4, 4'h4, 1'b0, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 4'h4, 4'h4, 1'b0, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 4'h4, 4'h4, 1'b0, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 4'h4, 4'h4, 1'b0, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0000, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 4'h4, 4'h4, 1'b1, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0100, 1'b1, 8'h77, 2'd2, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, 4'h0, 4'h0, 1'b1, 8'h11, 8'h22, 8'h77, 8'h44, 4'b0000, 1'b0, 8'h77, 2'd2, 1'b1, 1'b0);
        // burst owner bubbles while req3 waits
        tbl[20] = mk(1'b0, 4'h1, 4'h0, 1'b1, 8'hA0, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0, 1'b1);
        tbl[21] = mk(1'b0, 4'h8, 4'h8, 1'b1, 8'hA0, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b0, 8'hA0, 2'd0, 1'b0, 1'b1);
        tbl[22] = mk(1'b0, 4'h9, 4'h9, 1'b1, 8'hA1, 8'h22, 8'h33, 8'h44, 4'b0001, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b0);
        tbl[23] = mk(1'b0, 4'h8, 4'h8, 1'b1, 8'hA1, 8'h22, 8'h33, 8'h44, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0);

        do_reset();
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", {24'd0, out_data}, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_in_ready", {28'd0, in_ready}, 32'd0);

        for (int n = 0; n < 24; n++) begin
            if (tbl[n].rst) do_reset();
            @(negedge clk);
            in_valid = tbl[n].val; in_last = tbl[n].last; out_ready = tbl[n].ordy;
            in_data0 = tbl[n].d0; in_data1 = tbl[n].d1;
            in_data2 = tbl[n].d2; in_data3 = tbl[n].d3;
            #1;
            chk($sformatf("v%0d_in_ready", n), {28'd0, in_ready}, {28'd0, tbl[n].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", n), {31'd0, out_valid}, {31'd0, tbl[n].e_ov});
            chk($sformatf("v%0d_out_data", n), {24'd0, out_data}, {24'd0, tbl[n].e_od});
            chk($sformatf("v%0d_out_sel", n), {30'd0, out_sel}, {30'd0, tbl[n].e_sel});
            chk($sformatf("v%0d_out_last", n), {31'd0, out_last}, {31'd0, tbl[n].e_ol});
            chk($sformatf("v%0d_locked", n), {31'd0, locked}, {31'd0, tbl[n].e_lk});
        end

        // reset while a burst on req3 is open
        do_reset();
        @(negedge clk);
        in_valid = 4'b1000; in_last = 4'b0000; out_ready = 1'b1; in_data3 = 8'h99;
        @(posedge clk);
        #1;
        chk("t6_locked_before", {31'd0, locked}, 32'd1);
        chk("t6_sel_before", {30'd0, out_sel}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_async_locked", {31'd0, locked}, 32'd0);
        chk("t6_async_in_ready", {28'd0, in_ready}, 32'd0);
        chk("t6_async_out_sel", {30'd0, out_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 4'b1010; in_last = 4'b1010; in_data1 = 8'h22; in_data3 = 8'h44;
        #1;
        chk("t6_ready_after", {28'd0, in_ready}, 32'd2);
        @(posedge clk);
        #1;
        chk("t6_out_valid_after", {31'd0, out_valid}, 32'd1);
        chk("t6_out_sel_after", {30'd0, out_sel}, 32'd1);
        chk("t6_out_data_after", {24'd0, out_data}, 32'h22);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        prev_open = 1'b0;
        prev_j = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom) & 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data0  = 8'($urandom); in_data1 = 8'($urandom);
            in_data2  = 8'($urandom); in_data3 = 8'($urandom);
            #1;
            chk("rnd_in_ready", {28'd0, in_ready}, {28'd0, model_ready()});
            chk("rnd_onehot", {31'd0, $onehot0(in_ready)}, 32'd1);
            hs = in_valid & in_ready;
            j = -1;
            for (int i = 0; i < 4; i++) if (hs[i]) j = i;
            if (j >= 0) begin
                if (prev_open) chk("rnd_burst_atomic", j, prev_j);
                prev_open = !in_last[j];
                prev_j = j;
            end
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] || hs[i]) begin
                    wait_cnt[i] = 0;
                end else if (j >= 0 && in_last[j]) begin
                    wait_cnt[i]++;
                    chk("rnd_starvation", {31'd0, wait_cnt[i] > 4}, 32'd0);
                end
            end
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("rnd_out_data", {24'd0, out_data}, {24'd0, m_od});
            chk("rnd_out_last", {31'd0, out_last}, {31'd0, m_ol});
            chk("rnd_out_sel", {30'd0, out_sel}, m_os);
            chk("rnd_locked", {31'd0, locked}, {31'd0, m_owner >= 0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
